// File: rtl/fft_stage_sequencer_if.sv
// Butterfly-issue bus between the FFT stage sequencer and the datapath/coefficient mapper.
interface fft_stage_sequencer_if #(
  parameter int N_LOG2  = 5,
  parameter int STAGE_W = 4
) ();
  logic [STAGE_W-1:0] stage;
  logic               stage_start;
  logic               bf_valid;
  logic               bf_ready;
  logic [N_LOG2-1:0]  addr_a;
  logic [N_LOG2-1:0]  addr_b;
  logic [N_LOG2-2:0]  tw_idx;
  logic               rd_bank;

  modport master (
    output stage, stage_start, bf_valid, addr_a, addr_b, tw_idx, rd_bank,
    input  bf_ready
  );

  modport slave (
    input  stage, stage_start, bf_valid, addr_a, addr_b, tw_idx, rd_bank,
    output bf_ready
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Walks radix-2 FFT stages, issuing N/2 butterflies per stage, draining and swapping banks between stages.
// Addresses are combinational from stage/cnt; an op is held stable until bf_ready accepts it.
module fft_stage_sequencer #(
  parameter int N_LOG2       = 5,
  parameter int STAGE_W      = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  fft_stage_sequencer_if.master bf,
  output logic                  busy,
  output logic                  done,
  output logic                  result_bank
);
  localparam int CW = N_LOG2 - 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_LOG2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [7:0]         drain_cnt;
  logic [STAGE_W-1:0] stage_q;
  logic               rd_bank_q;
  logic               stage_start_q;
  logic               ld_first, ld_next, inc_cnt, ld_drain, ld_result;

  logic [N_LOG2-1:0]  cnt_ext, bit_s, mask, ins_a;
  logic [STAGE_W-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_first  = 1'b0;
    ld_next   = 1'b0;
    inc_cnt   = 1'b0;
    ld_drain  = 1'b0;
    ld_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          ld_first  = 1'b1;
        end
      end
      ISSUE: begin
        if (bf.bf_ready) begin
          inc_cnt = 1'b1;
          if (&cnt) begin
            state_nxt = DRAIN;
            ld_drain  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt <= 8'd1) begin
          if (stage_q < LAST_STAGE) begin
            state_nxt = ISSUE;
            ld_next   = 1'b1;
          end else begin
            state_nxt = DONE;
            ld_result = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      drain_cnt     <= '0;
      stage_q       <= '0;
      rd_bank_q     <= 1'b0;
      stage_start_q <= 1'b0;
      result_bank   <= 1'b0;
    end else begin
      stage_start_q <= ld_first | ld_next;
      if (ld_first) begin
        stage_q   <= STAGE_W'(1);
        rd_bank_q <= 1'b0;
        cnt       <= '0;
      end else if (ld_next) begin
        stage_q   <= stage_q + STAGE_W'(1);
        rd_bank_q <= ~rd_bank_q;
        cnt       <= '0;
      end else if (inc_cnt) begin
        cnt <= cnt + CW'(1);
      end
      if (ld_drain)
        drain_cnt <= 8'(DRAIN_CYCLES);
      else if (state == DRAIN && drain_cnt != 8'd0)
        drain_cnt <= drain_cnt - 8'd1;
      if (ld_result)
        result_bank <= ~rd_bank_q;
    end
  end

  // Insert a zero at bit s-1 of cnt: bits below stay, bits at/above shift up by one.
  always_comb begin
    cnt_ext = {1'b0, cnt};
    sh      = stage_q - STAGE_W'(1);
    bit_s   = N_LOG2'(1) << sh;
    mask    = bit_s - N_LOG2'(1);
    ins_a   = ((cnt_ext & ~mask) << 1) | (cnt_ext & mask);

    bf.bf_valid = (state == ISSUE);
    bf.addr_a   = '0;
    bf.addr_b   = '0;
    bf.tw_idx   = '0;
    if (state == ISSUE) begin
      bf.addr_a = ins_a;
      bf.addr_b = ins_a | bit_s;
      bf.tw_idx = (cnt & mask[CW-1:0]) << (LAST_STAGE - stage_q);
    end
  end

  assign bf.stage       = stage_q;
  assign bf.stage_start = stage_start_q;
  assign bf.rd_bank     = rd_bank_q;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Top-level sequencer for the in-place radix-2 FFT datapath. On a start pulse it walks stages 1..N_LOG2 and pulses the coefficient mapper's start for each stage while presenting the current stage number. It issues N/2 butterfly operations per stage, each carrying a read address pair and a twiddle index, over a valid/ready handshake. It drains the butterfly pipeline between stages and toggles the ping-pong memory bank once per stage.

Parameters:
N_LOG2, 5, log2 of FFT length N (N=32); legal range 2..15.
STAGE_W, 4, width of stage output; must satisfy 2^STAGE_W > N_LOG2.
DRAIN_CYCLES, 4, cycles held in DRAIN after each stage's last butterfly is accepted; legal range 1..255.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle FFT start request; ignored while busy=1.
stage  out  STAGE_W  current stage (1..N_LOG2); drives the coefficient mapper's stage input.
stage_start  out  1  one-cycle pulse at the beginning of each stage; drives the coefficient mapper's start input.
bf_valid  out  1  butterfly operation presented.
bf_ready  in  1  datapath accepts the operation when bf_valid=1 and bf_ready=1.
addr_a  out  N_LOG2  top butterfly input address.
addr_b  out  N_LOG2  bottom butterfly input address.
tw_idx  out  N_LOG2-1  twiddle index into the W_N table.
rd_bank  out  1  source bank for the current stage; the destination bank is ~rd_bank.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle pulse when the FFT completes.
result_bank  out  1  bank holding the final result; valid from the done pulse until the next start.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; stage=0; stage_start=0; bf_valid=0; addr_a=0; addr_b=0; tw_idx=0; rd_bank=0; busy=0; done=0; result_bank=0; op counter cnt=0; drain counter=0. Asserting reset mid-FFT aborts immediately; there is no resume.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> ISSUE next cycle with stage=1, rd_bank=0, cnt=0, stage_start=1 for that single cycle, busy=1.
- ISSUE:
  - bf_valid=1 throughout.
  - Outputs are combinational from stage s and cnt (N_LOG2-1 bits):
    - addr_a = cnt with a 0 bit inserted at bit position s-1.
    - addr_b = addr_a | 2^(s-1).
    - tw_idx = (cnt mod 2^(s-1)) << (N_LOG2-s).
  - Outputs hold stable while bf_ready=0.
  - On handshake: cnt++. If cnt was N/2-1, go to DRAIN with drain counter=DRAIN_CYCLES and bf_valid=0 next cycle.
- DRAIN:
  - Decrement the drain counter each cycle.
  - When it reaches 1 (i.e. after exactly DRAIN_CYCLES cycles in DRAIN):
    - If stage<N_LOG2: stage++, rd_bank toggles, cnt=0, stage_start pulse, go to ISSUE.
    - Otherwise go to DONE.
- DONE, one cycle: done=1; result_bank = rd_bank ^ 1; busy stays 1. Next cycle -> IDLE with busy=0. Stage holds its last value in IDLE.
- start asserted in any state other than IDLE is ignored and is not queued.
- With bf_ready held high, ISSUE lasts N/2 cycles per stage. Total time from accepted start to the done pulse = N_LOG2*(N/2+DRAIN_CYCLES) cycles, with done in the following cycle.
- cnt wraps naturally. No output ever exceeds its range; stage never exceeds N_LOG2.

Test Plan:
- Reset: hold rst_n=0, toggle clk and start -> all outputs 0, busy=0. Release reset -> outputs stay idle until start.
- Full run, N_LOG2=3, DRAIN_CYCLES=2, bf_ready=1, start pulse:
  - Stage 1 (rd_bank=0): addr_a=0,2,4,6; addr_b=1,3,5,7; tw_idx=0,0,0,0.
  - Stage 2 (rd_bank=1): addr_a=0,1,4,5; addr_b=2,3,6,7; tw_idx=0,2,0,2.
  - Stage 3 (rd_bank=0): addr_a=0,1,2,3; addr_b=4,5,6,7; tw_idx=0,1,2,3.
  - Required: exactly 3 stage_start pulses, each coincident with the first op of its stage; done 18 cycles after the first ISSUE cycle; result_bank=1.
- Backpressure: drive bf_ready low for 3 cycles at stage 2, op 1 -> addr_a=1, addr_b=3, tw_idx=2 held stable; no op skipped or repeated; done delayed by exactly 3 cycles.
- Start while busy: pulse start during stage 2 -> ignored; a single done pulse; a start pulse after return to IDLE restarts cleanly at stage=1, rd_bank=0.
- Reset mid-operation: rst_n low during stage 2 DRAIN -> outputs 0 asynchronously, without waiting for a clock edge; after release, no done pulse is ever generated.
- Default parameters (N_LOG2=5, DRAIN_CYCLES=4, bf_ready=1) -> 5 stages of 16 ops each; done 100 cycles after the first ISSUE cycle; result_bank=1; final stage tw_idx counts 0..15.
